// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and default timing for the HD44780 controller.
package lcd_pkg;
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam int CNT_W   = 20;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_POWERUP_CYC  = 750000;
  localparam int DEF_SETUP_CYC    = 4;
  localparam int DEF_E_PULSE_CYC  = 12;
  localparam int DEF_CMD_WAIT_CYC = 2500;
  localparam int DEF_CLR_WAIT_CYC = 100000;
  localparam int DEF_REFRESH_CYC  = 500000;

  typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_FRAME, ST_REFRESH} top_state_t;
  typedef enum logic [2:0] {WR_IDLE, WR_FETCH, WR_SETUP, WR_EHIGH, WR_WAIT} wr_state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction
endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD byte write: optional 2-cycle char fetch, RS/data setup, E pulse, post-write wait.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int E_PULSE_CYC  = DEF_E_PULSE_CYC,
  parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
  parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       is_data,
  input  logic [7:0] cmd,
  input  logic [7:0] char_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       idx_stb,
  output logic       done
);
  if (SETUP_CYC < 1 || E_PULSE_CYC < 1) begin : g_bad_pulse
    $error("lcd_byte_writer: SETUP_CYC and E_PULSE_CYC must be nonzero");
  end

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

  wr_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             long_wait, long_nx, e_nx, rs_nx, accept;
  logic [7:0]       data_nx;

  assign done    = (state == WR_WAIT) && (cnt == (long_wait ? CLR_LAST : CMD_LAST));
  // A new byte may be taken on the last wait cycle, so back-to-back writes lose no cycle.
  assign accept  = start && ((state == WR_IDLE) || done);
  assign idx_stb = accept && is_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WR_IDLE;
      cnt       <= '0;
      long_wait <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      long_wait <= long_nx;
      lcd_e     <= e_nx;
      lcd_rs    <= rs_nx;
      lcd_data  <= data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    long_nx  = long_wait;
    e_nx     = lcd_e;
    rs_nx    = lcd_rs;
    data_nx  = lcd_data;
    case (state)
      WR_FETCH: if (cnt == 1) begin
        data_nx  = char_in;
        rs_nx    = 1'b1;
        long_nx  = 1'b0;
        state_nx = WR_SETUP;
        cnt_nx   = '0;
      end
      WR_SETUP: if (cnt == SETUP_LAST) begin
        state_nx = WR_EHIGH;
        e_nx     = 1'b1;
        cnt_nx   = '0;
      end
      WR_EHIGH: if (cnt == E_LAST) begin
        state_nx = WR_WAIT;
        e_nx     = 1'b0;
        cnt_nx   = '0;
      end
      WR_WAIT: if (done) begin
        state_nx = WR_IDLE;
        cnt_nx   = '0;
      end
      default: cnt_nx = '0;
    endcase
    if (accept) begin
      cnt_nx = '0;
      if (is_data) state_nx = WR_FETCH;
      else begin
        state_nx = WR_SETUP;
        data_nx  = cmd;
        rs_nx    = 1'b0;
        long_nx  = (cmd == LCD_CLEAR);
      end
    end
  end
endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 16x2 controller: power-up wait, init commands, then endless 32-char frame refresh.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC  = DEF_POWERUP_CYC,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int E_PULSE_CYC  = DEF_E_PULSE_CYC,
  parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
  parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC,
  parameter int REFRESH_CYC  = DEF_REFRESH_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       frame_done
);
  if (POWERUP_CYC < 1 || POWERUP_CYC > CNT_MAX || SETUP_CYC > CNT_MAX ||
      E_PULSE_CYC > CNT_MAX || CMD_WAIT_CYC < 1 || CMD_WAIT_CYC > CNT_MAX ||
      CLR_WAIT_CYC < 1 || CLR_WAIT_CYC > CNT_MAX || REFRESH_CYC < 1 ||
      REFRESH_CYC > CNT_MAX) begin : g_bad_timing
    $error("lcd_hd44780_ctrl: timing parameter outside 20-bit counter range");
  end

  localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYC - 1);

  top_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [5:0]       step, step_nx, nstep;
  logic [4:0]       index_nx, char_pos;
  logic             frame_done_nx, start, is_data, idx_stb, wr_done;
  logic [7:0]       cmd;

  assign lcd_rw = 1'b0;
  // Byte selection looks one step ahead on done so the writer can chain without a gap.
  assign nstep  = wr_done ? step + 6'd1 : step;

  always_comb begin
    start    = 1'b0;
    is_data  = 1'b0;
    cmd      = 8'h00;
    char_pos = 5'd0;
    case (state)
      ST_INIT: if (nstep < 6'd4) begin
        start = 1'b1;
        cmd   = init_cmd(nstep[1:0]);
      end
      ST_FRAME: begin
        start = (nstep < 6'd34);
        if (nstep == 6'd0)       cmd = LCD_LINE1;
        else if (nstep == 6'd17) cmd = LCD_LINE2;
        else begin
          is_data  = 1'b1;
          char_pos = (nstep < 6'd17) ? nstep[4:0] - 5'd1 : nstep[4:0] - 5'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_POWERUP;
      cnt        <= '0;
      step       <= '0;
      index      <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      step       <= step_nx;
      index      <= index_nx;
      frame_done <= frame_done_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    step_nx       = nstep;
    index_nx      = idx_stb ? char_pos : index;
    frame_done_nx = 1'b0;
    case (state)
      ST_POWERUP: if (cnt == PU_LAST) begin
        state_nx = ST_INIT;
        cnt_nx   = '0;
        step_nx  = '0;
      end else cnt_nx = cnt + 1'b1;
      ST_INIT: if (wr_done && step == 6'd3) begin
        state_nx = ST_FRAME;
        step_nx  = '0;
      end
      ST_FRAME: if (wr_done && step == 6'd33) begin
        state_nx      = ST_REFRESH;
        cnt_nx        = '0;
        frame_done_nx = 1'b1;
      end
      ST_REFRESH: if (cnt == REF_LAST) begin
        state_nx = ST_FRAME;
        cnt_nx   = '0;
        step_nx  = '0;
        index_nx = '0;
      end else cnt_nx = cnt + 1'b1;
      default: state_nx = ST_POWERUP;
    endcase
  end

  lcd_byte_writer #(
    .SETUP_CYC    (SETUP_CYC),
    .E_PULSE_CYC  (E_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_wr (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_data  (is_data),
    .cmd      (cmd),
    .char_in  (char_in),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .idx_stb  (idx_stb),
    .done     (wr_done)
  );
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: byte scoreboard at each E rise, timing and reset checks.
module tb_lcd_hd44780_ctrl;
  import lcd_pkg::*;

  localparam int P  = 20;
  localparam int S  = 4;
  localparam int EP = 3;
  localparam int W  = 10;
  localparam int C  = 30;
  localparam int R  = 50;
  // cycles from FRAME entry to frame_done: one accept cycle, two commands, 32 data writes
  localparam int FRAME_LEN = 1 + 2 * (S + EP + W) + 32 * (2 + S + EP + W);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, frame_done;
  logic [7:0] lcd_data;
  logic [7:0] src;

  int total = 0;
  int bad   = 0;
  logic [8:0] expq[$];
  logic [8:0] hist[4];
  logic [8:0] held;
  logic e_prev = 1'b0;
  int   k = 0, cyc = 0, fd_count = 0, last_fd = 0, rel_cyc = 0;
  bit   have_fd = 0, have_rise = 0, last_clr = 0, in_reset = 1, first_pending = 0;

  always #5 clk = ~clk;

  // registered character source: 0x40+index, valid one cycle after index
  always_ff @(posedge clk) src <= 8'h40 + {3'b000, index};

  lcd_hd44780_ctrl #(
    .POWERUP_CYC (P), .SETUP_CYC (S), .E_PULSE_CYC (EP),
    .CMD_WAIT_CYC (W), .CLR_WAIT_CYC (C), .REFRESH_CYC (R)
  ) dut (
    .clk (clk), .rst (rst), .char_in (char_in), .index (index),
    .lcd_e (lcd_e), .lcd_rs (lcd_rs), .lcd_rw (lcd_rw),
    .lcd_data (lcd_data), .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    expq.push_back({1'b0, LCD_FUNC_SET});
    expq.push_back({1'b0, LCD_DISP_ON});
    expq.push_back({1'b0, LCD_ENTRY});
    expq.push_back({1'b0, LCD_CLEAR});
  endtask

  task automatic push_frame();
    expq.push_back({1'b0, LCD_LINE1});
    for (int i = 0; i < 16; i++) expq.push_back({1'b1, 8'(8'h40 + i)});
    expq.push_back({1'b0, LCD_LINE2});
    for (int i = 16; i < 32; i++) expq.push_back({1'b1, 8'(8'h40 + i)});
  endtask

  // One clock: sample at negedge, run all monitors, drive char_in for the next edge.
  task automatic tick();
    logic [8:0] cur, exp9;
    int min_gap;
    @(negedge clk);
    cyc++;
    cur = {lcd_rs, lcd_data};
    chk("rw_low", {31'd0, lcd_rw}, 32'd0);
    if (!in_reset) begin
      if (lcd_e && !e_prev) begin
        for (int i = 0; i < 4; i++) chk("setup_stable", {23'd0, hist[i]}, {23'd0, cur});
        if (first_pending) begin
          total++;
          assert (cyc - rel_cyc >= P + S - 1 && cyc - rel_cyc <= P + S + 1) else begin
            bad++;
            $error("FAIL first_e_rise observed=%0d expected=%0d+-1", cyc - rel_cyc, P + S);
          end
          first_pending = 0;
        end
        if (have_rise) begin
          min_gap = last_clr ? C : W;
          total++;
          assert (k >= min_gap) else begin
            bad++;
            $error("FAIL gap observed=%0d expected>=%0d", k, min_gap);
          end
        end
        total++;
        assert (expq.size() != 0) else begin
          bad++;
          $error("FAIL extra_byte observed=%0h expected=none", cur);
        end
        if (expq.size() != 0) begin
          exp9 = expq.pop_front();
          chk("byte", {23'd0, cur}, {23'd0, exp9});
          if (exp9 == {1'b0, LCD_LINE1}) chk("frame_start_index", {27'd0, index}, 32'd0);
        end
        last_clr  = (cur == {1'b0, LCD_CLEAR});
        have_rise = 1;
        held      = cur;
      end else if (lcd_e) begin
        chk("ehigh_stable", {23'd0, cur}, {23'd0, held});
      end
      if (frame_done) begin
        fd_count++;
        if (have_fd) chk("frame_spacing", cyc - last_fd, FRAME_LEN + R);
        have_fd = 1;
        last_fd = cyc;
      end
    end
    k = lcd_e ? 0 : k + 1;
    e_prev = lcd_e;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = cur;
    // only the FETCH sample cycle sees the true character; every other cycle is noise
    char_in = (k == W + 2) ? src : 8'($urandom);
  endtask

  initial begin
    int fd_base;
    bit found;
    rst = 1'b0;
    in_reset = 1;
    repeat (3) tick();
    chk("rst_index", {27'd0, index}, 32'd0);
    chk("rst_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

    push_init();
    repeat (4) push_frame();
    rst = 1'b1; in_reset = 0; rel_cyc = cyc; first_pending = 1;
    for (int n = 0; n < 5000 && fd_count < 3; n++) tick();
    chk("three_frames", fd_count, 32'd3);

    found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      found = lcd_e && lcd_rs && (lcd_data == 8'h47);
    end
    chk("reached_index7", {31'd0, found}, 32'd1);

    rst = 1'b0;
    #1;
    chk("arst_e", {31'd0, lcd_e}, 32'd0);
    chk("arst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("arst_data", {24'd0, lcd_data}, 32'd0);
    chk("arst_index", {27'd0, index}, 32'd0);
    chk("arst_frame_done", {31'd0, frame_done}, 32'd0);
    in_reset = 1;
    repeat (3) tick();

    expq.delete();
    push_init();
    push_frame();
    rst = 1'b1; in_reset = 0; rel_cyc = cyc; first_pending = 1;
    have_rise = 0; have_fd = 0; fd_base = fd_count;
    for (int n = 0; n < 2000 && fd_count == fd_base; n++) tick();
    chk("restart_frame", fd_count, fd_base + 1);
    chk("queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
